instruction_fetch_unit: RTL and testbench

// - Instruction-side producer for the single-cycle datapath: owns the PC, fetches 32-bit words

---
 rtl/instruction_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time and hands it to the core.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect raises fetch_fault and parks in FAULT.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_next,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        fetch_fault
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {S_START, S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;
`else
  typedef enum logic [2:0] {S_START, S_REQ, S_WAIT, S_HOLD} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        kill_q, kill_d;
  logic [31:0] tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  logic misalign;
  assign tgt      = redirect_target;
  assign misalign = |redirect_target[1:0];
`else
  logic unused_tgt_lo;
  assign tgt           = {redirect_target[31:2], 2'b00};
  assign unused_tgt_lo = ^redirect_target[1:0];
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    kill_d  = kill_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_d = fault_q;
`endif
    case (state_q)
      S_START: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d = imem_rsp_data;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          pc_d    = pc_q + 32'd4;
          instr_d = NOP_INSTR;
          state_d = S_REQ;
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      // A request accepted before the fault is still owed one response; absorb it here.
      S_FAULT: begin
        if (imem_rsp_valid) kill_d = 1'b0;
      end
`endif
      default: state_d = S_START;
    endcase

    // Redirect overrides everything above: new PC, held/arriving instruction discarded.
    if (redirect_valid) begin
      pc_d    = tgt;
      instr_d = NOP_INSTR;
      case (state_q)
        S_REQ: begin
          kill_d  = imem_req_ready;
          state_d = imem_req_ready ? S_WAIT : S_REQ;
        end
        S_WAIT: begin
          kill_d  = !imem_rsp_valid;
          state_d = imem_rsp_valid ? S_REQ : S_WAIT;
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        S_FAULT: begin
          kill_d  = kill_q && !imem_rsp_valid;
          state_d = (kill_q && !imem_rsp_valid) ? S_WAIT : S_REQ;
        end
`endif
        default: state_d = S_REQ;
      endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misalign) begin
        fault_d = 1'b1;
        state_d = S_FAULT;
      end else begin
        fault_d = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_START;
      pc_q    <= RESET_VECTOR;
      instr_q <= NOP_INSTR;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      kill_q  <= kill_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_addr      = pc_q;
  assign instr_valid    = (state_q == S_HOLD);
  assign instr          = instr_q;
  assign pc             = pc_q;
  assign pc_next        = pc_q + 32'd4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: behavioural memory, expected-address scoreboard,
// a table of sequential fetches and hand-written redirect/reset sequences.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        fetch_fault;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .pc              (pc),
    .pc_next         (pc_next),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fetch_fault     (fetch_fault)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_addr_q[$];

  // memory model state
  logic        mem_pend  = 1'b0;
  int          mem_cnt   = 0;
  int          mem_lat   = 0;
  logic [31:0] mem_addr_l = '0;
  logic        force_en  = 1'b0;
  logic [31:0] force_data = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    return {a[31:2], 2'b00} ^ 32'h5A5A_0013;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // One clock: record handshake, then advance the memory model and drop one-cycle pulses.
  task automatic tick();
    logic        fire;
    logic [31:0] a;
    fire = imem_req_valid && imem_req_ready;
    a    = imem_addr;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    if (fire) begin
      mem_pend   = 1'b1;
      mem_cnt    = mem_lat;
      mem_addr_l = a;
      if (exp_addr_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_req: got addr %h expected no request", a);
      end else begin
        chk32("req_addr", a, exp_addr_q.pop_front());
      end
    end
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = force_en ? force_data : mem_word(mem_addr_l);
        force_en       = 1'b0;
        mem_pend       = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
  endtask

  task automatic wait_valid(input string nm, input int exp_lat);
    int n;
    n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    chk1({nm, "_valid"}, instr_valid, 1'b1);
    if (exp_lat > 0) chk32({nm, "_latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic consume();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk1("consume_valid_drop", instr_valid, 1'b0);
    chk32("consume_nop", instr, NOP);
  endtask

  typedef struct {
    int          hold;
    int          lat;
    logic [31:0] addr;
    logic [31:0] word;
    logic [31:0] pcn;
  } vec_t;

  vec_t        vecs[2];
  logic [31:0] h_instr, h_pc, nxt;

  initial begin
    vecs[0] = '{hold: 5, lat: 3, addr: 32'h0, word: 32'h0010_0093, pcn: 32'h4};
    vecs[1] = '{hold: 0, lat: 2, addr: 32'h4, word: mem_word(32'h4), pcn: 32'h8};

    // asynchronous reset takes effect before any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk1("rst_instr_valid", instr_valid, 1'b0);
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk32("rst_pc", pc, 32'h0);
    chk32("rst_instr", instr, NOP);
    chk32("rst_pc_next", pc_next, 32'h4);
    chk1("rst_fault", fetch_fault, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    mem_lat = 0;

    // sequential fetches with core back-pressure
    for (int i = 0; i < 2; i++) begin
      exp_addr_q.push_back(vecs[i].addr);
      wait_valid("vec", vecs[i].lat);
      chk32("vec_instr", instr, vecs[i].word);
      chk32("vec_pc", pc, vecs[i].addr);
      chk32("vec_pc_next", pc_next, vecs[i].pcn);
      h_instr = instr;
      h_pc    = pc;
      for (int k = 0; k < vecs[i].hold; k++) begin
        tick();
        chk1("hold_valid", instr_valid, 1'b1);
        chk1("hold_no_req", imem_req_valid, 1'b0);
        chk32("hold_instr", instr, h_instr);
        chk32("hold_pc", pc, h_pc);
      end
      consume();
    end

    // HOLD at pc=8: redirect wins over instr_ready
    exp_addr_q.push_back(32'h8);
    wait_valid("A", 2);
    chk32("A_pc", pc, 32'h8);
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    exp_addr_q.push_back(32'h40);
    tick();
    instr_ready = 1'b0;
    chk1("A_valid_drop", instr_valid, 1'b0);
    chk32("A_addr", imem_addr, 32'h40);
    wait_valid("A2", 2);
    chk32("A_instr", instr, mem_word(32'h40));
    consume();

    // redirect while WAIT; stale DEADBEEF arrives later and must be dropped
    exp_addr_q.push_back(32'h44);
    force_en = 1'b1;
    force_data = 32'hDEAD_BEEF;
    mem_lat = 2;
    tick();
    chk1("B_wait_no_req", imem_req_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_target = 32'h100;
    tick();
    chk1("B_still_wait", imem_req_valid, 1'b0);
    tick();
    chk1("B_rsp_driven", imem_rsp_valid, 1'b1);
    tick();
    chk1("B_drop_valid", instr_valid, 1'b0);
    chk1("B_req_again", imem_req_valid, 1'b1);
    chk32("B_addr", imem_addr, 32'h100);
    mem_lat = 0;
    exp_addr_q.push_back(32'h100);
    wait_valid("B", 2);
    chk32("B_instr", instr, mem_word(32'h100));
    chk32("B_pc", pc, 32'h100);
    consume();

    // redirect in REQ without handshake, then PC wrap at the top of the address space
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    chk1("C_req", imem_req_valid, 1'b1);
    chk32("C_addr", imem_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    exp_addr_q.push_back(32'hFFFF_FFFC);
    wait_valid("C", 2);
    chk32("C_pc_next", pc_next, 32'h0);
    chk32("C_instr", instr, mem_word(32'hFFFF_FFFC));
    exp_addr_q.push_back(32'h0);
    consume();
    wait_valid("C2", 2);
    chk32("C2_pc", pc, 32'h0);
    chk32("C2_instr", instr, 32'h0010_0093);
    consume();

    // redirect in REQ with handshake: old request goes out, its response is killed
    exp_addr_q.push_back(32'h4);
    redirect_valid = 1'b1;
    redirect_target = 32'h200;
    tick();
    chk1("D_wait_valid", instr_valid, 1'b0);
    chk1("D_wait_req", imem_req_valid, 1'b0);
    tick();
    chk1("D_drop_valid", instr_valid, 1'b0);
    chk32("D_addr", imem_addr, 32'h200);
    exp_addr_q.push_back(32'h200);
    wait_valid("D", 2);
    chk32("D_pc", pc, 32'h200);
    consume();

    // misaligned redirect target
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h102;
    tick();
`ifdef FETCH_MISALIGN_TRAP_EN
    chk1("E_fault", fetch_fault, 1'b1);
    chk1("E_no_req", imem_req_valid, 1'b0);
    imem_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("E_fault_sticky", fetch_fault, 1'b1);
      chk1("E_no_req_fault", imem_req_valid, 1'b0);
      chk1("E_no_valid", instr_valid, 1'b0);
    end
    redirect_valid = 1'b1;
    redirect_target = 32'h300;
    tick();
    chk1("E_fault_clear", fetch_fault, 1'b0);
    chk32("E_addr_after", imem_addr, 32'h300);
    exp_addr_q.push_back(32'h300);
    wait_valid("E", 2);
    chk32("E_pc", pc, 32'h300);
    nxt = 32'h304;
`else
    chk32("E_addr", imem_addr, 32'h100);
    chk1("E_fault", fetch_fault, 1'b0);
    chk1("E_req", imem_req_valid, 1'b1);
    imem_req_ready = 1'b1;
    exp_addr_q.push_back(32'h100);
    wait_valid("E", 2);
    chk32("E_pc", pc, 32'h100);
    nxt = 32'h104;
`endif
    consume();

    // asynchronous reset while an instruction is held
    exp_addr_q.push_back(nxt);
    wait_valid("F", 2);
    #2 rst_n = 1'b0;
    #1;
    chk1("F_rst_valid", instr_valid, 1'b0);
    chk1("F_rst_req", imem_req_valid, 1'b0);
    chk32("F_rst_pc", pc, 32'h0);
    chk32("F_rst_instr", instr, NOP);
    mem_pend = 1'b0;
    imem_rsp_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_addr_q.push_back(32'h0);
    wait_valid("F2", 3);
    chk32("F2_pc", pc, 32'h0);
    consume();

    chk32("scoreboard_empty", 32'(exp_addr_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
